// File: rtl/uart_rx_capture.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, and a small
// first-word-fall-through FIFO with sticky framing-error and overflow flags.
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rx_i,
  output logic [DATA_BITS-1:0]             data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             busy_o,
  output logic                             frame_err_o,
  output logic                             overflow_o,
  input  logic                             clr_i
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_m, rx_s, rx_p;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;

  logic fall, stop_hit, push, ferr_set, pop, full, wr_ok;

  assign fall     = ~rx_s & rx_p;
  assign stop_hit = (state == STOP) && (cnt == CNT_LAST);
  assign push     = stop_hit & rx_s;
  assign ferr_set = stop_hit & ~rx_s;

  assign valid_o = (count != '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign pop     = valid_o & ready_i;
  assign full    = (count == CNT_FULL);
  // A full FIFO still accepts the byte when the head leaves on the same edge.
  assign wr_ok   = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= ferr_set | (frame_err_o & ~clr_i);
      unique case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[idx] <= rx_s;
            cnt        <= '0;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Back to IDLE either way; a held-low line needs a new edge to restart.
          if (cnt == CNT_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= (push & full & ~pop) | (overflow_o & ~clr_i);
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
